// File: rtl/cnt_seq_ctrl_pkg.sv
// cnt_seq_pkg: FSM state encoding and parameter defaults for the round sequencer.
package cnt_seq_pkg;
   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] RUN  = 2'b01;
   localparam logic [1:0] DONE = 2'b10;
   localparam int RND_W_DEF   = 4;
   localparam int TMO_CYC_DEF = 300;
endpackage

// File: rtl/cnt_seq_ctrl_edge_det.sv
// cnt_edge_det: registered rising-edge detector on the counter terminal flag.
module cnt_edge_det (
   input  logic clk,
   input  logic rst_b,
   input  logic cnt_end,
   output logic evt
);
   logic cnt_end_q;
   always_ff @(posedge clk or negedge rst_b)
      if (!rst_b) cnt_end_q <= 1'b0;
      else cnt_end_q <= cnt_end;
   assign evt = cnt_end & ~cnt_end_q;
endmodule

// File: rtl/cnt_seq_ctrl.sv
// cnt_seq_ctrl: runs the round counter for a programmed number of terminal events.
// Optional watchdog timeout enabled by defining CNT_SEQ_TIMEOUT_EN.
module cnt_seq_ctrl
   import cnt_seq_pkg::*;
#(
   parameter int RND_W   = RND_W_DEF,
   parameter int TMO_CYC = TMO_CYC_DEF
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             start,
   input  logic [RND_W-1:0] rounds,
   input  logic             cnt_end,
   output logic             cnt_en,
   output logic             busy,
   output logic             done,
   input  logic             done_ack,
   output logic [RND_W-1:0] round_cnt,
   output logic             err
);
   logic [1:0] state, state_nx;
   logic [RND_W-1:0] target, round_inc;
   logic evt, hit, tmo;
   if (TMO_CYC <= 256) begin : g_tmo_chk
      $error("TMO_CYC must exceed 256");
   end
   cnt_edge_det u_edge (.clk(clk), .rst_b(rst_b), .cnt_end(cnt_end), .evt(evt));
   assign round_inc = round_cnt + RND_W'(1);
   assign hit = evt & (round_inc == target);
`ifdef CNT_SEQ_TIMEOUT_EN
   localparam int TMR_W = $clog2(TMO_CYC);
   logic [TMR_W-1:0] timer;
   // an event in the limit cycle wins over the timeout
   assign tmo = (state == RUN) & ~evt & (timer == TMR_W'(TMO_CYC - 1));
   always_ff @(posedge clk or negedge rst_b)
      if (!rst_b) timer <= '0;
      else timer <= (state == RUN && !evt) ? timer + TMR_W'(1) : '0;
   always_ff @(posedge clk or negedge rst_b)
      if (!rst_b) err <= 1'b0;
      else if (tmo) err <= 1'b1;
      else if (state == DONE && done_ack) err <= 1'b0;
`else
   assign tmo = 1'b0;
   assign err = 1'b0;
`endif
   assign state_nx = (state == IDLE) ? (start ? ((rounds != '0) ? RUN : DONE) : IDLE)
                   : (state == RUN)  ? ((hit | tmo) ? DONE : RUN)
                   : (state == DONE) ? (done_ack ? IDLE : DONE)
                   : IDLE;
   always_ff @(posedge clk or negedge rst_b)
      if (!rst_b) state <= IDLE;
      else state <= state_nx;
   always_ff @(posedge clk or negedge rst_b)
      if (!rst_b) begin
         target    <= '0;
         round_cnt <= '0;
      end else if (state == IDLE && start) begin
         target    <= rounds;
         round_cnt <= '0;
      end else if (state == RUN && evt && round_cnt != target) begin
         round_cnt <= round_inc;
      end
   assign cnt_en = (state == RUN);
   assign busy   = (state != IDLE);
   assign done   = (state == DONE);
endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// tb_cnt_seq_ctrl: directed and random checks of cnt_seq_ctrl against a counter and sequence model.
module tb_cnt_seq_ctrl;
   localparam int RND_W = 4;
   localparam int TMO   = 300;
`ifdef CNT_SEQ_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif
   logic clk = 1'b0, rst_b = 1'b0, start = 1'b0, cnt_end = 1'b0, done_ack = 1'b0;
   logic cnt_en, busy, done, err;
   logic [RND_W-1:0] rounds = '0, round_cnt;
   logic [7:0] cnt_val = 8'h00;
   int total = 0, bad = 0, en_count = 0;
   int m_cnt, m_tgt, m_tmr;
   bit m_run, m_done, m_err, prev_end, noise, force0;
   always #5 clk = ~clk;
   cnt_seq_ctrl #(.RND_W(RND_W), .TMO_CYC(TMO)) dut (
      .clk(clk), .rst_b(rst_b), .start(start), .rounds(rounds), .cnt_end(cnt_end),
      .cnt_en(cnt_en), .busy(busy), .done(done), .done_ack(done_ack),
      .round_cnt(round_cnt), .err(err)
   );
   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
      end
   endtask
   task automatic check_outs(input string tag);
      chk({tag, ".cnt_en"}, cnt_en, int'(m_run));
      chk({tag, ".busy"}, busy, int'(m_run | m_done));
      chk({tag, ".done"}, done, int'(m_done));
      chk({tag, ".round_cnt"}, round_cnt, m_cnt);
      chk({tag, ".err"}, err, int'(m_err));
   endtask
   task automatic model_reset();
      m_run = 0; m_done = 0; m_err = 0; prev_end = 0;
      m_cnt = 0; m_tgt = 0; m_tmr = 0;
   endtask
   // one clock: apply inputs, advance the sequence model, then check at the falling edge
   task automatic step(input bit s, input int r, input bit a);
      bit ev, en_now;
      start = s; rounds = RND_W'(r); done_ack = a;
      cnt_end = noise ? 1'($urandom) : force0 ? 1'b0 : (cnt_val == 8'hff);
      ev = cnt_end && !prev_end;
      en_now = m_run;
      if (m_done) begin
         if (a) begin m_done = 0; m_err = 0; end
      end else if (m_run) begin
         if (ev) begin
            m_cnt++; m_tmr = 0;
            if (m_cnt == m_tgt) begin m_run = 0; m_done = 1; end
         end else if (TMO_EN && m_tmr == TMO - 1) begin
            m_run = 0; m_done = 1; m_err = 1;
         end else m_tmr++;
      end else if (s) begin
         m_cnt = 0; m_tmr = 0; m_tgt = r;
         m_done = (r == 0); m_run = (r != 0);
      end
      prev_end = cnt_end;
      @(posedge clk);
      if (en_now) cnt_val++;
      @(negedge clk);
      check_outs("step");
      if (cnt_en) en_count++;
   endtask
   task automatic run_to_done(input string tag, input int limit);
      int n = 0;
      while (!m_done && n < limit) begin step(0, 0, 0); n++; end
      chk({tag, ".done_bound"}, done, 1);
   endtask
   initial begin
      model_reset();
      noise = 0; force0 = 0;
      repeat (2) @(negedge clk);
      check_outs("reset");
      rst_b = 1'b1;
      cnt_val = 8'h00; en_count = 0;
      step(1, 2, 0);
      run_to_done("two_rounds", 2000);
      chk("two_rounds.en_cycles", en_count, 512);
      chk("two_rounds.round_cnt", round_cnt, 2);
      chk("two_rounds.counter", cnt_val, 0);
      step(0, 0, 1);
      cnt_val = 8'hff;
      step(0, 0, 0);
      en_count = 0;
      step(1, 1, 0);
      run_to_done("held_ff", 2000);
      chk("held_ff.en_cycles", en_count, 257);
      chk("held_ff.round_cnt", round_cnt, 1);
      chk("held_ff.counter", cnt_val, 0);
      step(0, 0, 1);
      en_count = 0;
      step(1, 0, 0);
      chk("zero_rounds.done", done, 1);
      chk("zero_rounds.round_cnt", round_cnt, 0);
      step(0, 0, 0);
      chk("zero_rounds.en_cycles", en_count, 0);
      step(0, 0, 1);
      step(1, 1, 0);
      repeat (4) step(1, 7, 0);
      step(0, 0, 1);
      run_to_done("ignore_start", 1000);
      step(1, 3, 0);
      step(1, 5, 1);
      chk("ack_and_start.busy", busy, 0);
      step(1, 1, 0);
      chk("start_after_ack.cnt_en", cnt_en, 1);
      run_to_done("start_after_ack", 1000);
      step(0, 0, 1);
      step(1, 3, 0);
      for (int n = 0; n < 1000 && m_cnt != 1; n++) step(0, 0, 0);
      repeat (3) step(0, 0, 0);
      chk("pre_rst.round_cnt", round_cnt, 1);
      rst_b = 1'b0;
      #1;
      model_reset();
      check_outs("async_rst");
      repeat (2) @(negedge clk);
      rst_b = 1'b1;
      repeat (3) step(0, 0, 0);
`ifdef CNT_SEQ_TIMEOUT_EN
      force0 = 1; en_count = 0;
      step(1, 3, 0);
      run_to_done("timeout", 1000);
      chk("timeout.err", err, 1);
      chk("timeout.en_cycles", en_count, 300);
      chk("timeout.round_cnt", round_cnt, 0);
      step(0, 0, 1);
      chk("timeout.err_clr", err, 0);
      force0 = 0;
`endif
      for (int seg = 0; seg < 8; seg++) begin
         noise = seg[0];
         repeat (500) begin
            step(($urandom % 16) == 0, noise ? int'($urandom % 16) : int'($urandom % 4),
                 ($urandom % 4) == 0);
         end
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/cnt_seq_ctrl.md
# cnt_seq_ctrl

Sequencing controller for the 8-bit free-running round counter. It drives the counter's `cnt_en` and consumes its `cnt_end` terminal flag. On a start request it enables the counter for a programmed number of full rounds (terminal events), stops it, and reports completion through a done/ack handshake. It sits between the control register interface and the counter.

## Interface
Parameters:
- `RND_W`, default 4: width of the round count and round target.
- `TMO_CYC`, default 300: watchdog limit in cycles between terminal events. Must be greater than 256. Used only with the timeout feature.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_b`  in  1  reset, asynchronous, active-low.
- `start`  in  1  single-cycle request to begin a sequence.
- `rounds`  in  RND_W  number of rounds to run; sampled only on accepted `start`.
- `cnt_end`  in  1  counter terminal flag; high while counter == 8'hff.
- `cnt_en`  out  1  counter enable.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  level; sequence complete, awaiting ack.
- `done_ack`  in  1  acknowledge; consumed only in DONE.
- `round_cnt`  out  RND_W  rounds completed in the current or last sequence.
- `err`  out  1  sequence ended by watchdog timeout.

## Operation
- States: IDLE, RUN, DONE. All outputs are registered or decoded from the state register only.
- Reset values: state=IDLE, `cnt_en`=0, `busy`=0, `done`=0, `round_cnt`=0, `err`=0, edge register=0, target=0, timer=0.
- `cnt_end` is registered every cycle, in every state, into `cnt_end_q`. A terminal event (`evt`) is `cnt_end & ~cnt_end_q`.
- IDLE:
  - `start`=1 and `rounds`≠0: latch target=`rounds`, clear `round_cnt`, go to RUN.
  - `start`=1 and `rounds`=0: clear `round_cnt`, go directly to DONE.
- RUN:
  - `cnt_en`=1.
  - On `evt`, `round_cnt` increments. If the incremented value equals target, go to DONE.
  - A `cnt_end` that is already high when RUN is entered is not an event. `cnt_end_q` is already 1 at that point, so that partial round is not counted.
- DONE:
  - `cnt_en`=0, `done`=1.
  - `done_ack`=1: go to IDLE. `done` is low the next cycle. `round_cnt` holds until the next accepted `start`.
- `start` in RUN or DONE is ignored and does not queue.
- `done_ack` outside DONE is ignored.
- `round_cnt` saturates at target and never wraps. Arithmetic is unsigned, RND_W bits.
- Reset asserted mid-sequence returns all state immediately to the reset values. `cnt_en` drops asynchronously.
- The controller never clears the counter. A sequence started with the counter mid-count counts its first terminal event as a round.

## Timing
- `start` accepted at edge N: state is RUN and `cnt_en`=1 from cycle N+1.
- Final `evt` seen in cycle M: state is DONE, `cnt_en`=0 and `done`=1 from cycle M+1. The counter samples `cnt_en`=1 at edge M, so it is left at 8'h00.
- Back-to-back sequences from a counter at 0: each round is 256 enabled cycles.
- `done_ack` at edge K: `busy`=0 and `done`=0 from K+1. A `start` at K+1 is accepted.
- `start` and `done_ack` asserted together in DONE: the ack is taken and the start is ignored.

## Configuration
- Macro `CNT_SEQ_TIMEOUT_EN`.
- Defined:
  - A timer clears on RUN entry and on each `evt`, and increments in RUN.
  - When it reaches `TMO_CYC`-1 without an `evt`, the next state is DONE with `err`=1.
  - `evt` in the same cycle takes priority, and the timer clears.
  - `err` clears when leaving DONE.
- Undefined: no timer logic; `err` is tied to 0.

## Structure
- Package `cnt_seq_pkg`:
  - State encoding localparams IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - Default `RND_W` and `TMO_CYC` constants.
- Sub-module `cnt_edge_det`: registered rising-edge detector with an async active-low reset (input `cnt_end`, output `evt`). It is instantiated once.
- The top level holds the FSM, the target/round registers and the optional timer.

## Test plan
- Counter at 0, `rounds`=2, `start` pulse → `cnt_en` high for 512 cycles. `done`=1 the cycle after the second `cnt_end` rise. `round_cnt`=2. Counter reads 8'h00.
- Counter held at 8'hff (`cnt_end`=1) at start, `rounds`=1 → the first rise is not counted. `done` comes after the counter wraps and reaches 8'hff again, 256 enabled cycles later.
- `rounds`=0 with `start` → `done`=1 one cycle later, `cnt_en` never high, `round_cnt`=0.
- `start` pulses during RUN and DONE are ignored. `done_ack`+`start` together in DONE → IDLE, no new sequence. A `start` the following cycle is accepted.
- `rst_b` low mid-RUN (`round_cnt`=1) → `cnt_en`, `busy`, `done` and `round_cnt` go to 0 immediately, and stay IDLE after release.
- With `CNT_SEQ_TIMEOUT_EN` and `cnt_end` tied 0, `rounds`=3 → `done`=1 and `err`=1 after 300 RUN cycles, `round_cnt`=0. `err` clears after `done_ack`.
